// File: rtl/phy_bringup_ctrl.sv
// rtl/phy_bringup_ctrl.sv - RGMII PHY bring-up and supervision sequencer
//
// Waits for both MMCM locks to stay high for LOCK_FILTER_CYCLES cycles in a row.
// It then holds the PHY in hardware reset for RST_HOLD_CYCLES cycles.
// Next it waits SETTLE_CYCLES cycles before enabling the RGMII RX/TX datapaths.
// In RUN it turns PHY interrupt falling edges into single-cycle link events.
//
// Ports:
//   clk125In        in   125 MHz system clock
//   rstBIn          in   asynchronous active-low reset
//   mmcm0LockedIn   in   MMCM0 lock (asynchronous)
//   mmcm1LockedIn   in   MMCM1 lock (asynchronous)
//   intBIn          in   PHY interrupt, active-low (asynchronous)
//   restartIn       in   single-cycle request to re-run the PHY reset sequence
//   phyRstBOut      out  PHY hardware reset, active-low
//   rxEnOut         out  RGMII RX datapath enable
//   txEnOut         out  RGMII TX datapath enable
//   linkEventOut    out  single-cycle pulse per qualified PHY interrupt
//   intCountOut     out  saturating count of link events since reset
//   stateOut        out  0 WAIT_LOCK, 1 PHY_RST, 2 SETTLE, 3 RUN
module phy_bringup_ctrl #(
    parameter int LOCK_FILTER_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 1250000,
    parameter int SETTLE_CYCLES      = 6250000,
    parameter int CNT_W              = 24
) (
    input  logic       clk125In,
    input  logic       rstBIn,
    input  logic       mmcm0LockedIn,
    input  logic       mmcm1LockedIn,
    input  logic       intBIn,
    input  logic       restartIn,
    output logic       phyRstBOut,
    output logic       rxEnOut,
    output logic       txEnOut,
    output logic       linkEventOut,
    output logic [7:0] intCountOut,
    output logic [1:0] stateOut
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        PHY_RST   = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [1:0]       m0_sync;
    logic [1:0]       m1_sync;
    logic [1:0]       int_sync;
    logic [CNT_W-1:0] filt_cnt;
    logic [CNT_W-1:0] timer;
    logic             int_prev;
    logic             lock_ok;
    logic             int_b;

    // The interrupt synchronizer resets high so that the pin reads as idle out of reset.
    always_ff @(posedge clk125In or negedge rstBIn) begin
        if (!rstBIn) begin
            m0_sync  <= 2'b00;
            m1_sync  <= 2'b00;
            int_sync <= 2'b11;
        end else begin
            m0_sync  <= {m0_sync[0], mmcm0LockedIn};
            m1_sync  <= {m1_sync[0], mmcm1LockedIn};
            int_sync <= {int_sync[0], intBIn};
        end
    end

    assign lock_ok  = m0_sync[1] & m1_sync[1];
    assign int_b    = int_sync[1];
    assign stateOut = state;

    always_ff @(posedge clk125In or negedge rstBIn) begin
        if (!rstBIn) begin
            state        <= WAIT_LOCK;
            filt_cnt     <= '0;
            timer        <= '0;
            int_prev     <= 1'b1;
            phyRstBOut   <= 1'b0;
            rxEnOut      <= 1'b0;
            txEnOut      <= 1'b0;
            linkEventOut <= 1'b0;
            intCountOut  <= 8'd0;
        end else begin
            linkEventOut <= 1'b0;
            if (state == WAIT_LOCK) begin
                if (!lock_ok) begin
                    filt_cnt <= '0;
                end else if (filt_cnt == FILT_LAST) begin
                    state    <= PHY_RST;
                    filt_cnt <= '0;
                    timer    <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else if (!lock_ok) begin
                // Lock loss outranks everything else.
                state      <= WAIT_LOCK;
                filt_cnt   <= '0;
                timer      <= '0;
                phyRstBOut <= 1'b0;
                rxEnOut    <= 1'b0;
                txEnOut    <= 1'b0;
            end else if (restartIn && state != PHY_RST) begin
                // A restart during PHY_RST is dropped so that the reset pulse width stays fixed.
                state      <= PHY_RST;
                timer      <= '0;
                phyRstBOut <= 1'b0;
                rxEnOut    <= 1'b0;
                txEnOut    <= 1'b0;
            end else begin
                case (state)
                    PHY_RST: begin
                        if (timer == RST_LAST) begin
                            state      <= SETTLE;
                            timer      <= '0;
                            phyRstBOut <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            state    <= RUN;
                            timer    <= '0;
                            rxEnOut  <= 1'b1;
                            txEnOut  <= 1'b1;
                            // If the interrupt is already low on entry, it does not count as an edge.
                            int_prev <= int_b;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    RUN: begin
                        int_prev <= int_b;
                        if (int_prev && !int_b) begin
                            linkEventOut <= 1'b1;
                            if (intCountOut != 8'hFF) begin
                                intCountOut <= intCountOut + 8'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
